// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM encoding, default slave address and IMU register map
package i2c_pkg;
   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, MACK, IGNORE
   } i2c_state_t;
   localparam logic [6:0] DEV_ADDR_MPU     = 7'h68;
   localparam logic [7:0] REG_SMPLRT_DIV   = 8'h19;
   localparam logic [7:0] REG_CONFIG       = 8'h1A;
   localparam logic [7:0] REG_GYRO_CONFIG  = 8'h1B;
   localparam logic [7:0] REG_ACCEL_CONFIG = 8'h1C;
   localparam logic [7:0] REG_DATA_FIRST   = 8'h3B;
   localparam logic [7:0] REG_DATA_LAST    = 8'h48;
   localparam logic [7:0] REG_PWR_MGMT_1   = 8'h6B;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: 2-FF synchronizers for SCL/SDA plus edge, START and STOP detection
module i2c_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop
);
   // bits [1:0] synchronize, bit [2] is the one-cycle-delayed copy; idle bus is high
   logic [2:0] scl_q, sda_q;
   always_ff @(posedge clk)
      if (rst) begin
         scl_q <= '1;
         sda_q <= '1;
      end else begin
         scl_q <= {scl_q[1:0], scl_i};
         sda_q <= {sda_q[1:0], sda_i};
      end
   assign sda      = sda_q[1];
   assign scl_rise = scl_q[1] & ~scl_q[2];
   assign scl_fall = ~scl_q[1] & scl_q[2];
   assign start    = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
   assign stop     = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
endmodule

// File: rtl/i2c_slave_regport.sv
// i2c_slave_regport: I2C slave with auto-incrementing register pointer and a simple register port
module i2c_slave_regport import i2c_pkg::*; #(
   parameter logic [6:0] DEV_ADDR = DEV_ADDR_MPU
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_wr,
   output logic       reg_rd,
   input  logic [7:0] reg_rdata,
   output logic       busy
);
   logic sda, scl_rise, scl_fall, start, stop;
   i2c_state_t state, nxt;
   logic [7:0] sh, rbuf;
   logic [2:0] cnt;
   logic done, rd_q;
   logic bus_ev, shifting, byte_end, match, ack_on, ld_ptr, wr_go, mack_ok;
   logic rd_go, inc, load_rd, shift_out, rel;

   i2c_line_sync u_sync (
      .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .sda(sda),
      .scl_rise(scl_rise), .scl_fall(scl_fall), .start(start), .stop(stop)
   );

   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= nxt;

   always_comb begin
      nxt = state;
      if (stop) nxt = IDLE;
      else if (start) nxt = ADDR;
      else case (state)
         ADDR:               if (byte_end) nxt = match ? ADDR_ACK : IGNORE;
         ADDR_ACK:           if (scl_fall) nxt = sh[0] ? RDATA : PTR;
         PTR:                if (byte_end) nxt = PTR_ACK;
         PTR_ACK, WDATA_ACK: if (scl_fall) nxt = WDATA;
         WDATA:              if (byte_end) nxt = WDATA_ACK;
         RDATA:              if (scl_fall & cnt == 3'd7) nxt = MACK;
         MACK:               if (scl_rise & sda) nxt = IGNORE; else if (scl_fall) nxt = RDATA;
         default: ;
      endcase
   end

   always_comb begin
      bus_ev    = start | stop;
      shifting  = state inside {ADDR, PTR, WDATA};
      byte_end  = shifting & scl_fall & done & ~bus_ev;
      match     = sh[7:1] == DEV_ADDR;
      ack_on    = byte_end & (state != ADDR | match);
      ld_ptr    = byte_end & state == PTR;
      wr_go     = byte_end & state == WDATA;
      mack_ok   = state == MACK & scl_rise & ~sda;
      // the first read is requested as soon as the R/W bit of a matching address is seen
      rd_go     = mack_ok | state == ADDR & scl_rise & cnt == 3'd7 & sh[6:0] == DEV_ADDR & sda;
      inc       = mack_ok | state == WDATA_ACK & scl_fall;
      load_rd   = scl_fall & (state == ADDR_ACK & sh[0] | state == MACK);
      shift_out = scl_fall & state == RDATA & cnt != 3'd7;
      rel       = bus_ev | scl_fall & (state == ADDR_ACK & ~sh[0] | state == PTR_ACK
                  | state == WDATA_ACK | state == RDATA & cnt == 3'd7);
   end

   always_ff @(posedge clk)
      if (rst) begin
         sda_oe    <= 1'b0;
         busy      <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_wr    <= 1'b0;
         reg_rd    <= 1'b0;
         rd_q      <= 1'b0;
         sh        <= '0;
         rbuf      <= '0;
         cnt       <= '0;
         done      <= 1'b0;
      end else begin
         reg_wr <= wr_go;
         reg_rd <= rd_go;
         rd_q   <= reg_rd;
         if (rd_q) rbuf <= reg_rdata;
         sda_oe <= rel ? 1'b0 : ack_on ? 1'b1 : load_rd ? ~rbuf[7] : shift_out ? ~sh[7] : sda_oe;
         busy   <= stop ? 1'b0 : (ack_on & state == ADDR) | busy;
         if (ld_ptr) reg_addr <= sh;
         else if (inc) reg_addr <= reg_addr + 8'd1;
         if (wr_go) reg_wdata <= sh;
         if (load_rd) sh <= {rbuf[6:0], 1'b0};
         else if (shift_out) sh <= {sh[6:0], 1'b0};
         else if (shifting & scl_rise) sh <= {sh[6:0], sda};
         // done marks a complete byte so the fall right after START is not mistaken for a byte end
         cnt  <= bus_ev | load_rd ? '0 : shifting & scl_rise | state == RDATA & scl_fall ? cnt + 3'd1 : cnt;
         done <= bus_ev | scl_fall ? 1'b0 : shifting & scl_rise ? cnt == 3'd7 : done;
      end
endmodule

// File: tb/tb_i2c_slave_regport.sv
// tb_i2c_slave_regport: randomized I2C master transactions checked against a register-file model
module tb_i2c_slave_regport;
   import i2c_pkg::*;
   localparam int W = 6;
   logic clk = 1'b0, rst = 1'b1, scl = 1'b1, sda_m = 1'b1, load = 1'b0;
   logic sda_oe, reg_wr, reg_rd, busy, sda_line, oe_seen;
   logic [7:0] reg_addr, reg_wdata, reg_rdata;
   logic [7:0] regs [256];
   logic [7:0] init_val [256];
   logic [7:0] ref_mem [256];
   logic [15:0] wr_q [$];
   logic [7:0] rd_q [$];
   logic [7:0] wq [$];
   int vectors = 0, errs = 0;

   always #5 clk = ~clk;
   assign sda_line = sda_m & ~sda_oe;

   i2c_slave_regport #(.DEV_ADDR(DEV_ADDR_MPU)) dut (
      .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_line), .sda_oe(sda_oe),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
      .reg_rdata(reg_rdata), .busy(busy)
   );

   // emulated register file behind the port
   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < 256; i++) regs[i] <= init_val[i];
         reg_rdata <= 8'h00;
      end else begin
         if (reg_wr) regs[reg_addr] <= reg_wdata;
         if (reg_rd) reg_rdata <= regs[reg_addr];
      end
   end

   always @(negedge clk) begin
      if (reg_wr) wr_q.push_back({reg_addr, reg_wdata});
      if (reg_rd) rd_q.push_back(reg_addr);
      if (sda_oe) oe_seen = 1'b1;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bit_cycle(input logic b, output logic s);
      sda_m = b; tick(W);
      scl = 1'b1; tick(W);
      s = sda_line; tick(W);
      scl = 1'b0; tick(W);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; tick(W);
      scl = 1'b1; tick(W);
      sda_m = 1'b0; tick(W);
      scl = 1'b0; tick(W);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; tick(W);
      scl = 1'b1; tick(W);
      sda_m = 1'b1; tick(W);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
      bit_cycle(1'b1, s);
      ack = ~s;
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_cycle(1'b1, s);
         b[i] = s;
      end
      bit_cycle(~mack, s);
   endtask

   task automatic do_write(input logic [7:0] p);
      logic ack;
      logic [7:0] a;
      wr_q.delete();
      i2c_start();
      write_byte({DEV_ADDR_MPU, 1'b0}, ack); chk("wr_addr_ack", 16'(ack), 16'(1));
      write_byte(p, ack); chk("wr_ptr_ack", 16'(ack), 16'(1));
      foreach (wq[i]) begin
         write_byte(wq[i], ack);
         chk("wr_data_ack", 16'(ack), 16'(1));
      end
      chk("wr_busy", 16'(busy), 16'(1));
      i2c_stop(); tick(4);
      chk("wr_busy_stop", 16'(busy), 16'(0));
      chk("wr_count", 16'(wr_q.size()), 16'(wq.size()));
      foreach (wq[i]) begin
         a = p + 8'(i);
         chk("wr_strobe", wr_q.size() > i ? wr_q[i] : 16'hxxxx, {a, wq[i]});
         ref_mem[a] = wq[i];
      end
      chk("wr_ptr_final", 16'(reg_addr), 16'(p + 8'(wq.size())));
   endtask

   task automatic do_read(input logic [7:0] p, input int n);
      logic ack;
      logic [7:0] b, a;
      i2c_start();
      write_byte({DEV_ADDR_MPU, 1'b0}, ack); chk("rd_waddr_ack", 16'(ack), 16'(1));
      write_byte(p, ack); chk("rd_ptr_ack", 16'(ack), 16'(1));
      rd_q.delete(); wr_q.delete();
      i2c_start();
      write_byte({DEV_ADDR_MPU, 1'b1}, ack); chk("rd_raddr_ack", 16'(ack), 16'(1));
      for (int i = 0; i < n; i++) begin
         read_byte(i < n - 1, b);
         a = p + 8'(i);
         chk("rd_data", 16'(b), 16'(ref_mem[a]));
         chk("rd_strobe_addr", 16'(rd_q.size() > i ? rd_q[i] : 8'hxx), 16'(a));
      end
      // after the NACK the slave must stay off the bus
      oe_seen = 1'b0;
      for (int i = 0; i < 9; i++) bit_cycle(1'b1, b[0]);
      chk("rd_ignore_oe", 16'(oe_seen), 16'(0));
      chk("rd_count", 16'(rd_q.size()), 16'(n));
      chk("rd_no_wr", 16'(wr_q.size()), 16'(0));
      chk("rd_busy", 16'(busy), 16'(1));
      i2c_stop(); tick(4);
      chk("rd_busy_stop", 16'(busy), 16'(0));
   endtask

   initial begin
      logic ack, s;
      logic [7:0] p;
      for (int i = 0; i < 256; i++) begin
         init_val[i] = 8'($urandom);
         ref_mem[i] = init_val[i];
      end
      load = 1'b1; tick(4);
      load = 1'b0; rst = 1'b0; tick(2);
      chk("rst_sda_oe", 16'(sda_oe), 16'(0));
      chk("rst_reg_wr", 16'(reg_wr), 16'(0));
      chk("rst_reg_rd", 16'(reg_rd), 16'(0));
      chk("rst_busy", 16'(busy), 16'(0));
      chk("rst_reg_addr", 16'(reg_addr), 16'(0));
      chk("rst_reg_wdata", 16'(reg_wdata), 16'(0));

      wq.delete(); wq.push_back(8'h00);
      do_write(REG_PWR_MGMT_1);

      wq.delete(); wq.push_back(8'hA5);
      do_write(REG_DATA_FIRST);
      do_read(REG_DATA_FIRST, 1);

      do_read(8'hFE, 3);

      wr_q.delete(); rd_q.delete(); oe_seen = 1'b0;
      i2c_start();
      write_byte(8'hA0, ack); chk("nomatch_ack", 16'(ack), 16'(0));
      write_byte(8'h55, ack); chk("nomatch_data_ack", 16'(ack), 16'(0));
      chk("nomatch_busy", 16'(busy), 16'(0));
      i2c_stop(); tick(4);
      chk("nomatch_oe", 16'(oe_seen), 16'(0));
      chk("nomatch_wr", 16'(wr_q.size()), 16'(0));
      chk("nomatch_rd", 16'(rd_q.size()), 16'(0));

      wr_q.delete();
      i2c_start();
      write_byte({DEV_ADDR_MPU, 1'b0}, ack);
      write_byte(8'h20, ack);
      for (int i = 0; i < 4; i++) bit_cycle(1'($urandom), s);
      i2c_stop(); tick(4);
      chk("abort_no_wr", 16'(wr_q.size()), 16'(0));
      chk("abort_busy", 16'(busy), 16'(0));
      wq.delete(); wq.push_back(8'($urandom)); wq.push_back(8'($urandom));
      do_write(8'h20);

      for (int k = 0; k < 4; k++) begin
         p = 8'($urandom);
         wq.delete();
         for (int j = 0; j < int'($urandom_range(1, 3)); j++) wq.push_back(8'($urandom));
         do_write(p);
         do_read(p - 8'($urandom_range(0, 1)), int'($urandom_range(1, 4)));
      end

      wq.delete(); wq.push_back(8'h5A);
      do_write(8'h40);
      i2c_start();
      write_byte({DEV_ADDR_MPU, 1'b0}, ack);
      write_byte(8'h40, ack);
      i2c_start();
      write_byte({DEV_ADDR_MPU, 1'b1}, ack);
      chk("rst_bit_driven", 16'(sda_oe), 16'(1));
      rst = 1'b1; tick(1);
      chk("rst_oe_clear", 16'(sda_oe), 16'(0));
      rst = 1'b0;
      wr_q.delete(); rd_q.delete(); oe_seen = 1'b0;
      for (int i = 0; i < 9; i++) bit_cycle(1'b1, s);
      chk("rst_quiet_oe", 16'(oe_seen), 16'(0));
      chk("rst_quiet_wr", 16'(wr_q.size()), 16'(0));
      chk("rst_quiet_rd", 16'(rd_q.size()), 16'(0));
      chk("rst_quiet_busy", 16'(busy), 16'(0));
      chk("rst_ptr_clear", 16'(reg_addr), 16'(0));
      i2c_stop(); tick(4);
      do_read(8'($urandom), 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule

// File: doc/i2c_slave_regport.md
# i2c_slave_regport

I2C slave (responder) for the sensor interface: the target-side counterpart of the FPGA I2C master that polls the IMU. It decodes START/STOP, matches a 7-bit device address, and keeps an 8-bit register pointer with auto-increment. Writes and reads are forwarded to a simple register port, so the block can emulate an IMU register file in simulation and on a second FPGA. It drives SDA open-drain only; the top level owns the pad.

## Interface
- `DEV_ADDR`, default `7'h68`: 7-bit slave address that the block ACKs.
- `clk`  in  1: system clock, 50 MHz nominal.
- `rst`  in  1: synchronous, active-high reset.
- `scl_i`  in  1: raw SCL from the pad, asynchronous to `clk`.
- `sda_i`  in  1: raw SDA from the pad, asynchronous to `clk`.
- `sda_oe`  out  1: 1 pulls SDA low; 0 releases it. The pad is `sda = sda_oe ? 1'b0 : 1'bz`.
- `reg_addr`  out  8: current register pointer.
- `reg_wdata`  out  8: write data; valid while `reg_wr` = 1.
- `reg_wr`  out  1: one-cycle write strobe.
- `reg_rd`  out  1: one-cycle read request for `reg_addr`.
- `reg_rdata`  in  8: read data, sampled exactly 1 clk after `reg_rd`.
- `busy`  out  1: high from an address-matched START until STOP.

## Operation
- `scl_i` and `sda_i` each pass through a 2-FF synchronizer. Edge and condition detection uses the synchronized value and its 1-cycle-delayed copy:
  - `scl_rise` / `scl_fall`: SCL edges.
  - `start`: SDA falls while SCL is high.
  - `stop`: SDA rises while SCL is high.
- SDA is sampled on `scl_rise`. `sda_oe` changes only on `scl_fall`, or on `stop`/`start`.
- A 3-bit bit counter and an 8-bit shift register track the byte; bytes are MSB first.
- FSM states and transitions:
  - IDLE: on `start` go to ADDR.
  - ADDR: shift 8 bits. Address ≠ `DEV_ADDR` → IGNORE. Match → on the 8th `scl_fall` set `sda_oe`=1 and go to ADDR_ACK.
  - ADDR_ACK: on `scl_fall`, release SDA. R/W=0 → PTR. R/W=1 → load the read byte into the shifter, drive bit 7 (`sda_oe` = ~bit), go to RDATA.
  - PTR: shift 8 bits. On the 8th `scl_fall`: `reg_addr` ← byte, ACK, go to PTR_ACK.
  - PTR_ACK: on `scl_fall`, release SDA and go to WDATA.
  - WDATA: shift 8 bits. On the 8th `scl_fall`: `reg_wdata` ← byte, pulse `reg_wr`, ACK, go to WDATA_ACK.
  - WDATA_ACK: on `scl_fall`, release SDA, `reg_addr` += 1, return to WDATA.
  - RDATA: drive bits on each `scl_fall`. After the 8th bit, release SDA and go to MACK.
  - MACK: sample SDA on `scl_rise`.
    - 0 (ACK): `reg_addr` += 1, pulse `reg_rd` on the next cycle, load the byte, drive its bit 7 on `scl_fall`, return to RDATA.
    - 1 (NACK): go to IGNORE.
  - IGNORE: SDA released; wait for `start` or `stop`.
- `stop` in any state → IDLE; `sda_oe`=0 and `busy`=0 in the same cycle.
- `start` in any state (repeated START) → ADDR. `sda_oe` is cleared; `reg_addr` is kept, so the pointer persists across the restart.
- `reg_addr` wraps from 8'hFF to 8'h00.
- `rst` in mid-transfer: all state clears; the bus stays released until the next START.

## Timing
- Reset values:
  - `sda_oe`, `reg_wr`, `reg_rd`, `busy` = 0.
  - `reg_addr`, `reg_wdata` = 8'h00.
  - FSM = IDLE.
- Input-to-detect latency is 3 clk. SCL high and low phases must each be ≥ 8 clk; the 100 kHz master gives 250 clk.
- Read path, address-matched R/W=1:
  - `reg_rd` pulses on the cycle after the 8th `scl_rise`.
  - `reg_rdata` is captured 1 clk later, well before the ACK-ending `scl_fall`.
- Write path: `reg_wr` is a single cycle, asserted on the 8th `scl_fall` + 1 clk.
- ACK hold: `sda_oe`=1 from the 8th `scl_fall` to the 9th `scl_fall`. `sda_oe` changes 1 clk after the detected `scl_fall`. This is SDA hold time, not setup.
- If `stop` and `scl_fall` are detected in the same cycle, `stop` wins.

## Structure
- Shared package `i2c_pkg` holds:
  - the FSM state enum;
  - `DEV_ADDR_MPU` = 7'h68;
  - the IMU register constants: 8'h3B–8'h48 data registers, and 8'h6B/8'h19/8'h1A/8'h1B/8'h1C configuration registers, for benches and emulators.
- Sub-module `i2c_line_sync`: the 2-FF synchronizers plus `scl_rise`, `scl_fall`, `start`, `stop` detection.
- The FSM, shifter and pointer stay in the top module.

## Test plan
- Write 8'h6B then 8'h00 to address 0x68 → one `reg_wr` with `reg_addr`=8'h6B and `reg_wdata`=8'h00; three ACKs observed; `busy` drops on STOP.
- Write pointer 8'h3B, repeated START, read with address byte 8'hD1, `reg_rdata`=8'hA5, master NACK → SDA bits 1010_0101; `reg_rd` at `reg_addr`=8'h3B; IGNORE; then IDLE on STOP.
- Burst read from 8'hFE: master ACK, ACK, then NACK → `reg_rd` at 8'hFE, 8'hFF, 8'h00 (wrap).
- Address byte 8'hA0 → no ACK (`sda_oe` stays 0), no strobes, `busy`=0.
- STOP injected mid-WDATA after 4 bits → no `reg_wr`; IDLE; the next transaction works.
- `rst` asserted while driving a 0 read bit → `sda_oe`=0 on the next clk; no strobes until the next START.
